// File: rtl/umi_tx_arbiter.sv
// Round-robin, message-atomic merge of NUM_INPUTS UMI request streams onto one registered tx port.
// The winner holds the grant until its eom beat transfers, so messages never interleave.
module umi_tx_arbiter #(
  parameter int NUM_INPUTS = 2,
  parameter int DW         = 256,
  parameter int AW         = 64,
  parameter int CW         = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_INPUTS*DW-1:0] in_data,
  input  logic [NUM_INPUTS*AW-1:0] in_srcaddr,
  input  logic [NUM_INPUTS*AW-1:0] in_dstaddr,
  input  logic [NUM_INPUTS*CW-1:0] in_cmd,
  input  logic [NUM_INPUTS-1:0]    in_valid,
  output logic [NUM_INPUTS-1:0]    in_ready,
  output logic [DW-1:0]            out_data,
  output logic [AW-1:0]            out_srcaddr,
  output logic [AW-1:0]            out_dstaddr,
  output logic [CW-1:0]            out_cmd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_INPUTS-1:0]    grant
);

  localparam int IW  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int EOM = 22;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state_q;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] rr_ptr_d;
  logic [IW-1:0] lock_idx_q;
  logic [IW-1:0] win_idx;
  logic          win_found;
  logic          win_vld;
  logic          can_load;
  logic          xfer;
  logic [IW:0]   cand;
  logic [IW:0]   nxt;

  logic [DW-1:0] sel_data;
  logic [AW-1:0] sel_srcaddr;
  logic [AW-1:0] sel_dstaddr;
  logic [CW-1:0] sel_cmd;

  logic [DW-1:0] out_data_q;
  logic [AW-1:0] out_srcaddr_q;
  logic [AW-1:0] out_dstaddr_q;
  logic [CW-1:0] out_cmd_q;
  logic          out_valid_q;

  // Winner search: LOCKED pins the owner; IDLE scans upward from rr_ptr with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (state_q == LOCKED) begin
      win_found = 1'b1;
      win_idx   = lock_idx_q;
    end else begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
        if (cand >= (IW+1)'(NUM_INPUTS)) begin
          cand = cand - (IW+1)'(NUM_INPUTS);
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
          if (!win_found && in_valid[i] && (cand[IW-1:0] == IW'(i))) begin
            win_found = 1'b1;
            win_idx   = IW'(i);
          end
        end
      end
    end
  end

  always_comb begin
    grant       = '0;
    sel_data    = '0;
    sel_srcaddr = '0;
    sel_dstaddr = '0;
    sel_cmd     = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (win_found && (win_idx == IW'(i))) begin
        grant[i]    = 1'b1;
        sel_data    = in_data[i*DW +: DW];
        sel_srcaddr = in_srcaddr[i*AW +: AW];
        sel_dstaddr = in_dstaddr[i*AW +: AW];
        sel_cmd     = in_cmd[i*CW +: CW];
      end
    end
  end

  always_comb begin
    nxt      = {1'b0, win_idx} + (IW+1)'(1);
    rr_ptr_d = nxt[IW-1:0];
    if (nxt >= (IW+1)'(NUM_INPUTS)) begin
      rr_ptr_d = '0;
    end
  end

  assign can_load = !out_valid_q || out_ready;
  assign in_ready = grant & {NUM_INPUTS{can_load}};
  assign win_vld  = |(grant & in_valid);
  assign xfer     = win_vld && can_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      lock_idx_q    <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_srcaddr_q <= '0;
      out_dstaddr_q <= '0;
      out_cmd_q     <= '0;
    end else if (xfer) begin
      out_valid_q   <= 1'b1;
      out_data_q    <= sel_data;
      out_srcaddr_q <= sel_srcaddr;
      out_dstaddr_q <= sel_dstaddr;
      out_cmd_q     <= sel_cmd;
      // Only a finished message moves the round-robin pointer.
      if (sel_cmd[EOM]) begin
        state_q  <= IDLE;
        rr_ptr_q <= rr_ptr_d;
      end else begin
        state_q    <= LOCKED;
        lock_idx_q <= win_idx;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_data    = out_data_q;
  assign out_srcaddr = out_srcaddr_q;
  assign out_dstaddr = out_dstaddr_q;
  assign out_cmd     = out_cmd_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_umi_tx_arbiter.sv
// Scoreboard bench for umi_tx_arbiter: a driver issues per-input beats, a monitor pops expected beats.
module tb_umi_tx_arbiter;

  localparam int NI = 4;
  localparam int DW = 64;
  localparam int AW = 16;
  localparam int CW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NI*DW-1:0]  in_data;
  logic [NI*AW-1:0]  in_srcaddr;
  logic [NI*AW-1:0]  in_dstaddr;
  logic [NI*CW-1:0]  in_cmd;
  logic [NI-1:0]     in_valid;
  logic [NI-1:0]     in_ready;
  logic [DW-1:0]     out_data;
  logic [AW-1:0]     out_srcaddr;
  logic [AW-1:0]     out_dstaddr;
  logic [CW-1:0]     out_cmd;
  logic              out_valid;
  logic              out_ready;
  logic [NI-1:0]     grant;

  always #5 clk = ~clk;

  umi_tx_arbiter #(.NUM_INPUTS(NI), .DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_srcaddr(in_srcaddr), .in_dstaddr(in_dstaddr),
    .in_cmd(in_cmd), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_srcaddr(out_srcaddr), .out_dstaddr(out_dstaddr),
    .out_cmd(out_cmd), .out_valid(out_valid), .out_ready(out_ready),
    .grant(grant)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [CW-1:0] cmd;
    int            gap;
  } beat_t;

  int    checks   = 0;
  int    failures = 0;
  beat_t exp_q[$];
  beat_t src_q[NI][$];
  beat_t per_exp[NI][$];
  beat_t cur[NI];
  bit    act[NI];
  int    gapc[NI];
  bit    fire[NI];
  bit    ordy;
  bit    rand_rdy;
  bit    per_mode;
  int    open_src;
  beat_t mon_e;
  int    mon_s;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  function automatic beat_t mk(int inp, int tag, bit eom, int gap);
    beat_t b;
    b.data    = {8'(inp), 24'(tag), 32'(32'(tag) * 32'h9E37_79B1)};
    b.src     = 16'(tag * 7 + 4096);
    b.dst     = {8'(inp), 8'(tag)};
    b.cmd     = (32'(tag) * 32'h0101_0101) ^ 32'h0000_00C3;
    b.cmd[22] = eom;
    b.gap     = gap;
    return b;
  endfunction

  function automatic bit busy();
    bit r;
    r = (exp_q.size() != 0) || out_valid;
    for (int i = 0; i < NI; i++) begin
      if (src_q[i].size() != 0 || per_exp[i].size() != 0 || act[i]) r = 1'b1;
    end
    return r;
  endfunction

  // One cycle: update drivers at negedge, then predict which inputs transfer at the next posedge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      if (act[i] && fire[i]) act[i] = 1'b0;
      else if (act[i] && gapc[i] > 0) gapc[i]--;
      if (!act[i] && src_q[i].size() != 0) begin
        cur[i]  = src_q[i].pop_front();
        act[i]  = 1'b1;
        gapc[i] = cur[i].gap;
      end
      in_valid[i]            = act[i] && (gapc[i] == 0);
      in_data[i*DW +: DW]    = cur[i].data;
      in_srcaddr[i*AW +: AW] = cur[i].src;
      in_dstaddr[i*AW +: AW] = cur[i].dst;
      in_cmd[i*CW +: CW]     = cur[i].cmd;
    end
    out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : ordy;
    #1;
    for (int i = 0; i < NI; i++) fire[i] = !rst && in_valid[i] && in_ready[i];
  endtask

  task automatic flush();
    for (int i = 0; i < NI; i++) begin
      src_q[i].delete();
      act[i]  = 1'b0;
      gapc[i] = 0;
      fire[i] = 1'b0;
    end
    in_valid = '0;
  endtask

  task automatic drain(int budget, string nm);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    chk(nm, 64'(busy()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Monitor: every accepted output beat is compared against the scoreboard.
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      if (!per_mode) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%h required=none", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_data", out_data, mon_e.data);
          chk("beat_addr", 64'({out_srcaddr, out_dstaddr}), 64'({mon_e.src, mon_e.dst}));
          chk("beat_cmd", 64'(out_cmd), 64'(mon_e.cmd));
        end
      end else begin
        mon_s = int'(out_data[DW-1 -: 8]);
        if (mon_s >= NI || per_exp[mon_s].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stray_beat actual=%h required=queued", out_data);
        end else begin
          if (open_src >= 0) chk("rand_contiguous", 64'(mon_s), 64'(open_src));
          mon_e = per_exp[mon_s].pop_front();
          chk("rand_data", out_data, mon_e.data);
          chk("rand_addr", 64'({out_srcaddr, out_dstaddr}), 64'({mon_e.src, mon_e.dst}));
          chk("rand_cmd", 64'(out_cmd), 64'(mon_e.cmd));
          open_src = out_cmd[22] ? -1 : mon_s;
        end
      end
    end
  end

  initial begin
    #800000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    beat_t b_hold;
    int    n;
    int    viol;
    int    bad;
    int    idle;
    int    tag;
    int    inp;
    int    len;
    bit    done1;
    logic [DW-1:0] snap_d;
    logic [CW-1:0] snap_c;

    rst = 1'b1; in_valid = '0; in_data = '0; in_srcaddr = '0; in_dstaddr = '0;
    in_cmd = '0; out_ready = 1'b0; ordy = 1'b1; rand_rdy = 1'b0; per_mode = 1'b0;
    open_src = -1;
    for (int i = 0; i < NI; i++) begin
      cur[i] = mk(i, 0, 1'b1, 0); act[i] = 1'b0; gapc[i] = 0; fire[i] = 1'b0;
    end
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_cmd", 64'(out_cmd), 64'd0);
    chk("rst_out_addr", 64'({out_srcaddr, out_dstaddr}), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);

    // Single beat from input 0, eom set, data 0xA5.
    b = mk(0, 1, 1'b1, 0);
    b.data = 64'hA5;
    src_q[0].push_back(b); exp_q.push_back(b);
    step();
    chk("single_fire", 64'(fire[0]), 64'd1);
    step();
    chk("single_out_valid", 64'(out_valid), 64'd1);
    chk("single_out_data", out_data, 64'hA5);
    drain(20, "single_drain");

    // Atomicity: rr_ptr is now 1, so input 1 wins and holds across its valid gap.
    b = mk(1, 10, 1'b0, 0); src_q[1].push_back(b); exp_q.push_back(b);
    b = mk(1, 11, 1'b0, 2); src_q[1].push_back(b); exp_q.push_back(b);
    b = mk(1, 12, 1'b1, 0); src_q[1].push_back(b); exp_q.push_back(b);
    b = mk(0, 13, 1'b1, 0); src_q[0].push_back(b); exp_q.push_back(b);
    step();
    chk("atom_first_grant", 64'(grant), 64'b0010);
    viol = 0; done1 = 1'b0; n = 0;
    while (n < 30) begin
      if (in_ready[0]) viol++;
      if (fire[1] && cur[1].cmd[22]) begin
        done1 = 1'b1;
        break;
      end
      step();
      n++;
    end
    chk("atom_in_ready0_blocked", 64'(viol), 64'd0);
    chk("atom_eom_seen", 64'(done1), 64'd1);
    drain(30, "atom_drain");

    // Backpressure: hold beat 20 for five cycles, then beat 21 loads the cycle ready returns.
    b_hold = mk(3, 20, 1'b0, 0); src_q[3].push_back(b_hold); exp_q.push_back(b_hold);
    b = mk(3, 21, 1'b1, 0); src_q[3].push_back(b); exp_q.push_back(b);
    n = 0;
    step();
    while (!fire[3] && n < 10) begin
      step();
      n++;
    end
    chk("bp_first_fire", 64'(fire[3]), 64'd1);
    ordy = 1'b0;
    step();
    snap_d = out_data; snap_c = out_cmd; bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      if (!out_valid || out_data !== snap_d || out_cmd !== snap_c || in_ready != '0) bad++;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    chk("bp_held_data", snap_d, b_hold.data);
    ordy = 1'b1;
    step();
    chk("bp_reload_same_cycle", 64'(fire[3]), 64'd1);
    drain(20, "bp_drain");

    // Mid-message reset: beat 1 of input 2 is discarded, then input 0 wins from rr_ptr 0.
    b_hold = mk(2, 30, 1'b0, 0); src_q[2].push_back(b_hold);
    for (int k = 1; k < 4; k++) src_q[2].push_back(mk(2, 30 + k, k == 3, 0));
    n = 0;
    step();
    while (!fire[2] && n < 10) begin
      step();
      n++;
    end
    chk("mr_first_fire", 64'(fire[2]), 64'd1);
    ordy = 1'b0;
    step();
    chk("mr_beat1_held", out_data, b_hold.data);
    rst = 1'b1;
    step();
    chk("mr_out_valid_cleared", 64'(out_valid), 64'd0);
    rst = 1'b0;
    flush();
    ordy = 1'b1;
    b = mk(0, 40, 1'b1, 0); src_q[0].push_back(b); exp_q.push_back(b);
    for (int k = 0; k < 4; k++) begin
      b = mk(2, 41 + k, k == 3, 0); src_q[2].push_back(b); exp_q.push_back(b);
    end
    step();
    chk("mr_grant_input0", 64'(grant), 64'b0001);
    drain(30, "mr_drain");

    // Fairness: four always-valid inputs, single-beat messages, strict 0,1,2,3 rotation.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NI; i++) begin
        b = mk(i, 50 + r * 4 + i, 1'b1, 0); src_q[i].push_back(b); exp_q.push_back(b);
      end
    end
    n = 0;
    step();
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    idle = 0;
    for (int k = 1; k < 16; k++) begin
      step();
      if (!out_valid) idle++;
    end
    chk("rr_no_idle", 64'(idle), 64'd0);
    drain(30, "rr_drain");

    // Randomised traffic on inputs 0..2: per-input order, contiguity and bit-exact payload.
    per_mode = 1'b1;
    rand_rdy = 1'b1;
    open_src = -1;
    tag = 1000;
    for (int m = 0; m < 1000; m++) begin
      inp = $urandom_range(0, 2);
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        b = mk(inp, tag, k == len - 1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
        tag++;
        src_q[inp].push_back(b);
        per_exp[inp].push_back(b);
      end
    end
    drain(40000, "rand_drain");
    chk("rand_last_message_closed", 64'(open_src + 1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
